// File: rtl/kv_cache_pkg.sv
// rtl/kv_cache_pkg.sv - shared sizing, line type and FSM encoding for the KV line fetcher
package kv_cache_pkg;

  localparam int KV_DATA_WIDTH = 32;
  localparam int KV_LINE_SIZE  = 4;

  function automatic int lineoffset_width(input int line_size);
    return (line_size > 1) ? $clog2(line_size) : 1;
  endfunction

  localparam int LINEOFFSET_WIDTH = lineoffset_width(KV_LINE_SIZE);

  typedef logic [KV_LINE_SIZE-1:0][KV_DATA_WIDTH-1:0] kv_line_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } kv_fetch_state_e;

endpackage

// File: rtl/kv_fetch_credit.sv
// rtl/kv_fetch_credit.sv - outstanding-read counter that permits memory request issue
module kv_fetch_credit #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_issue,
  input  logic i_return,
  output logic o_permit
);

  localparam int CRW = $clog2(MAX_OUTSTANDING + 1);

  logic [CRW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_issue && !i_return) begin
      cnt_d = cnt_q + CRW'(1);
    end else if (!i_issue && i_return) begin
      cnt_d = cnt_q - CRW'(1);
    end
  end

  // A returning beat frees its slot in the same cycle, so issue resumes on the return itself.
  assign o_permit = (cnt_q < CRW'(MAX_OUTSTANDING)) || i_return;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kv_line_fetcher.sv
// rtl/kv_line_fetcher.sv - critical-word-first line refill engine for the KV cache fetch port
module kv_line_fetcher
  import kv_cache_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_SIZE       = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic [ADDR_WIDTH-1:0]                i_req_addr,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  output logic                                 o_mem_valid,
  input  logic                                 i_mem_ready,
  input  logic [DATA_WIDTH-1:0]                i_mem_rdata,
  input  logic                                 i_mem_rvalid,
  output logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] o_line_data,
  output logic                                 o_line_valid,
  input  logic                                 i_line_ready
);

  localparam int OW = lineoffset_width(LINE_SIZE);
  localparam int CW = OW + 1;

  kv_fetch_state_e                      state_q, state_d;
  logic [ADDR_WIDTH-OW-1:0]             base_q, base_d;
  logic [OW-1:0]                        start_q, start_d;
  logic [CW-1:0]                        issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]                        resp_cnt_q, resp_cnt_d;
  logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] line_q, line_d;
  logic                                 req_ready_q;
  logic                                 line_valid_q;

  logic          in_burst;
  logic          credit_ok;
  logic          mem_valid;
  logic          issue_fire;
  logic          resp_fire;
  logic          last_resp;
  logic [OW-1:0] issue_off;
  logic [OW-1:0] resp_off;

  assign in_burst   = (state_q == ST_BURST);
  assign resp_fire  = in_burst && i_mem_rvalid;
  assign mem_valid  = in_burst && (issue_cnt_q != CW'(LINE_SIZE)) && credit_ok;
  assign issue_fire = mem_valid && i_mem_ready;
  assign last_resp  = resp_fire && (resp_cnt_q == CW'(LINE_SIZE - 1));

  // Offsets wrap naturally in OW bits; the base half of the address never moves.
  assign issue_off = start_q + issue_cnt_q[OW-1:0];
  assign resp_off  = start_q + resp_cnt_q[OW-1:0];

  kv_fetch_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_issue  (issue_fire),
    .i_return (resp_fire),
    .o_permit (credit_ok)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    start_d     = start_q;
    issue_cnt_d = issue_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    line_d      = line_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid && req_ready_q) begin
          state_d     = ST_BURST;
          base_d      = i_req_addr[ADDR_WIDTH-1:OW];
          start_d     = i_req_addr[OW-1:0];
          issue_cnt_d = '0;
          resp_cnt_d  = '0;
        end
      end
      ST_BURST: begin
        if (issue_fire) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        if (resp_fire) begin
          line_d[resp_off] = i_mem_rdata;
          resp_cnt_d       = resp_cnt_q + CW'(1);
        end
        if (last_resp) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (line_valid_q && i_line_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      start_q      <= '0;
      issue_cnt_q  <= '0;
      resp_cnt_q   <= '0;
      line_q       <= '0;
      req_ready_q  <= 1'b1;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      start_q      <= start_d;
      issue_cnt_q  <= issue_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      line_q       <= line_d;
      req_ready_q  <= (state_d == ST_IDLE);
      line_valid_q <= (state_d == ST_DONE);
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_mem_valid  = mem_valid;
  assign o_mem_addr   = {base_q, issue_off};
  assign o_line_data  = line_q;
  assign o_line_valid = line_valid_q;

endmodule

// File: tb/tb_kv_line_fetcher.sv
// tb/tb_kv_line_fetcher.sv - scoreboard bench for the KV line fetcher
module tb_kv_line_fetcher;
  import kv_cache_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LS = 4;
  localparam int MO = 2;

  logic          i_clk        = 1'b0;
  logic          i_rstn       = 1'b0;
  logic [AW-1:0] i_req_addr   = '0;
  logic          i_req_valid  = 1'b0;
  logic          o_req_ready;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_valid;
  logic          i_mem_ready  = 1'b0;
  logic [DW-1:0] i_mem_rdata  = '0;
  logic          i_mem_rvalid = 1'b0;
  kv_line_t      o_line_data;
  logic          o_line_valid;
  logic          i_line_ready = 1'b1;

  kv_line_fetcher #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS), .MAX_OUTSTANDING(MO)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .o_mem_addr(o_mem_addr), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid),
    .o_line_data(o_line_data), .o_line_valid(o_line_valid), .i_line_ready(i_line_ready)
  );

  always #5 i_clk = ~i_clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [AW-1:0] exp_addr_q[$];
  kv_line_t      exp_line_q[$];
  int            exp_lat_q[$];
  int            acc_cyc_q[$];
  logic [AW-1:0] pend_addr_q[$];
  int            pend_due_q[$];

  int mem_lat = 1;
  bit hold_ready = 0;
  int stray_left = 0;
  int cur_lat_exp = -1;
  bit b2b_check = 0;
  int accept_cnt = 0;
  int line_cnt = 0;
  int issue_total = 0;
  int stall_cycles = 0;
  int hs_cyc = -1;
  bit prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  bit prev_line_wait = 0;
  kv_line_t prev_line = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory model drives inputs at negedge, then checks outputs once they settle.
  always @(negedge i_clk) begin
    logic [AW-1:0] a, e, base;
    kv_line_t l;
    int lat, ac, st;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    if (stray_left > 0) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hDEAD_BEEF;
      stray_left   = stray_left - 1;
    end else if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
      a = pend_addr_q.pop_front();
      void'(pend_due_q.pop_front());
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = mem_word(a);
    end
    i_mem_ready = !hold_ready;
    #1;
    if (!i_rstn) begin
      prev_stall     = 0;
      prev_line_wait = 0;
    end else begin
      if (i_req_valid && o_req_ready) begin
        if (b2b_check) begin
          tests_run++;
          if (cyc !== hs_cyc + 1) begin
            tests_failed++;
            $display("FAIL b2b_accept_cycle: got %0d expected %0d", cyc, hs_cyc + 1);
          end
          b2b_check = 0;
        end
        base = i_req_addr & ~32'(LS - 1);
        st   = int'(i_req_addr & 32'(LS - 1));
        for (int i = 0; i < LS; i++) begin
          exp_addr_q.push_back(base | 32'((st + i) % LS));
          l[i] = mem_word(base | 32'(i));
        end
        exp_line_q.push_back(l);
        exp_lat_q.push_back(cur_lat_exp);
        acc_cyc_q.push_back(cyc);
        accept_cnt++;
      end
      if (prev_stall) begin
        tests_run++;
        if (o_mem_valid !== 1'b1 || o_mem_addr !== prev_addr) begin
          tests_failed++;
          $display("FAIL stall_hold: valid %0b addr %h expected valid 1 addr %h",
                   o_mem_valid, o_mem_addr, prev_addr);
        end
      end
      if (o_mem_valid && !i_mem_ready) stall_cycles++;
      prev_stall = o_mem_valid && !i_mem_ready;
      prev_addr  = o_mem_addr;
      if (o_mem_valid && i_mem_ready) begin
        tests_run++;
        if (exp_addr_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_issue: addr %h with no refill pending", o_mem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          if (o_mem_addr !== e) begin
            tests_failed++;
            $display("FAIL issue_addr: got %h expected %h", o_mem_addr, e);
          end
        end
        tests_run++;
        if (pend_addr_q.size() >= MO) begin
          tests_failed++;
          $display("FAIL credit_limit: %0d outstanding at issue, limit %0d", pend_addr_q.size() + 1, MO);
        end
        pend_addr_q.push_back(o_mem_addr);
        pend_due_q.push_back(cyc + mem_lat);
        issue_total++;
      end
      if (o_line_valid) begin
        if (prev_line_wait) begin
          tests_run++;
          if (o_line_data !== prev_line || o_req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL line_hold: data %h req_ready %0b expected data %h req_ready 0",
                     o_line_data, o_req_ready, prev_line);
          end
        end
        if (i_line_ready) begin
          tests_run++;
          if (exp_line_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_line: data %h with no refill pending", o_line_data);
          end else begin
            l  = exp_line_q.pop_front();
            lat = exp_lat_q.pop_front();
            ac = acc_cyc_q.pop_front();
            if (o_line_data !== l) begin
              tests_failed++;
              $display("FAIL line_data: got %h expected %h", o_line_data, l);
            end
            if (lat >= 0) begin
              tests_run++;
              if (cyc - ac !== lat) begin
                tests_failed++;
                $display("FAIL line_latency: got %0d expected %0d", cyc - ac, lat);
              end
            end
          end
          line_cnt++;
          hs_cyc = cyc;
        end
        prev_line_wait = !i_line_ready;
        prev_line      = o_line_data;
      end else begin
        prev_line_wait = 0;
      end
    end
  end

  task automatic do_req(input logic [AW-1:0] addr, input int lat, input string what);
    int n0 = accept_cnt;
    int k = 0;
    cur_lat_exp = lat;
    i_req_addr  = addr;
    i_req_valid = 1'b1;
    while (accept_cnt == n0 && k < 300) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    i_req_valid = 1'b0;
    tests_run++;
    if (accept_cnt == n0) begin
      tests_failed++;
      $display("FAIL %s_accept_timeout: accepts %0d expected %0d", what, accept_cnt, n0 + 1);
    end
  endtask

  task automatic wait_lines(input int n, input string what);
    int k = 0;
    while (line_cnt < n && k < 300) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    tests_run++;
    if (line_cnt < n) begin
      tests_failed++;
      $display("FAIL %s_line_timeout: lines %0d expected %0d", what, line_cnt, n);
    end
  endtask

  task automatic wait_mem_idle();
    int k = 0;
    while (pend_addr_q.size() > 0 && k < 100) begin
      @(posedge i_clk);
      k++;
    end
    #1;
  endtask

  task automatic check_idle_outputs(input string what);
    tests_run++;
    if (o_req_ready !== 1'b1 || o_mem_valid !== 1'b0 || o_line_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_flags: req_ready %0b mem_valid %0b line_valid %0b expected 1 0 0",
               what, o_req_ready, o_mem_valid, o_line_valid);
    end
    tests_run++;
    if (o_mem_addr !== '0) begin
      tests_failed++;
      $display("FAIL %s_mem_addr: got %h expected 0", what, o_mem_addr);
    end
    tests_run++;
    if (o_line_data !== '0) begin
      tests_failed++;
      $display("FAIL %s_line_data: got %h expected 0", what, o_line_data);
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_idle_outputs("reset_held");
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    check_idle_outputs("reset_released");
  endtask

  task automatic test_aligned();
    int l0 = line_cnt;
    mem_lat = 1;
    do_req(32'h100, LS + 2, "aligned");
    wait_lines(l0 + 1, "aligned");
  endtask

  task automatic test_wrap();
    int l0 = line_cnt;
    do_req(32'h10E, LS + 2, "wrap");
    wait_lines(l0 + 1, "wrap");
  endtask

  task automatic test_backpressure();
    int l0 = line_cnt;
    int n0 = issue_total;
    int s0 = stall_cycles;
    int k = 0;
    i_line_ready = 1'b0;
    do_req(32'h307, -1, "bp");
    while (issue_total < n0 + 1 && k < 100) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    hold_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    hold_ready = 1'b0;
    tests_run++;
    if (stall_cycles - s0 < 3) begin
      tests_failed++;
      $display("FAIL bp_stall_seen: got %0d stall cycles expected at least 3", stall_cycles - s0);
    end
    k = 0;
    while (!o_line_valid && k < 100) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    tests_run++;
    if (o_line_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_line_valid: got %0b expected 1", o_line_valid);
    end
    repeat (5) @(posedge i_clk);
    #1;
    i_line_ready = 1'b1;
    wait_lines(l0 + 1, "bp");
  endtask

  task automatic test_credit();
    int l0 = line_cnt;
    wait_mem_idle();
    mem_lat = 4;
    do_req(32'h405, 11, "credit");
    wait_lines(l0 + 1, "credit");
    wait_mem_idle();
    mem_lat = 1;
  endtask

  task automatic test_reset_mid();
    int l0;
    int n0 = issue_total;
    int k = 0;
    wait_mem_idle();
    do_req(32'h0A1, -1, "rst_mid");
    while (issue_total < n0 + 2 && k < 100) begin
      @(posedge i_clk);
      k++;
    end
    @(posedge i_clk);
    #1;
    i_rstn = 1'b0;
    #1;
    check_idle_outputs("rst_mid_immediate");
    exp_addr_q.delete();
    exp_line_q.delete();
    exp_lat_q.delete();
    acc_cyc_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    wait_mem_idle();
    stray_left = 2;
    repeat (4) @(posedge i_clk);
    #1;
    tests_run++;
    if (o_req_ready !== 1'b1 || o_mem_valid !== 1'b0 || o_line_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_stray_ignored: req_ready %0b mem_valid %0b line_valid %0b expected 1 0 0",
               o_req_ready, o_mem_valid, o_line_valid);
    end
    l0 = line_cnt;
    do_req(32'h200, LS + 2, "rst_after");
    wait_lines(l0 + 1, "rst_after");
  endtask

  task automatic test_back_to_back();
    int l0 = line_cnt;
    int n0 = accept_cnt;
    int k = 0;
    cur_lat_exp = LS + 2;
    i_req_addr  = 32'h500;
    i_req_valid = 1'b1;
    while (accept_cnt == n0 && k < 100) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    i_req_addr = 32'h52B;
    b2b_check  = 1'b1;
    k = 0;
    while (accept_cnt < n0 + 2 && k < 100) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    i_req_valid = 1'b0;
    tests_run++;
    if (accept_cnt !== n0 + 2) begin
      tests_failed++;
      $display("FAIL b2b_accepts: got %0d expected %0d", accept_cnt - n0, 2);
    end
    wait_lines(l0 + 2, "b2b");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_wrap();
    test_backpressure();
    test_credit();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(posedge i_clk);
    #1;
    tests_run++;
    if (exp_line_q.size() != 0 || exp_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d lines and %0d reads still expected", exp_line_q.size(), exp_addr_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
